// File: rtl/ieee754_pkg.sv
// Shared definitions for the FP operation arbiter: op codes, FSM encoding, request bundle.
package ieee754_pkg;

    localparam int FP_WIDTH = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // One operation request as seen by the FP unit.
    typedef struct packed {
        logic [FP_WIDTH-1:0] a;
        logic [FP_WIDTH-1:0] b;
        logic [1:0]          op;
    } fp_req_t;

endpackage

// File: rtl/ieee754_rr_arbiter.sv
// Two-way round-robin arbiter: a tie goes to the requester not granted last time.
module ieee754_rr_arbiter (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant,
    output logic       idx
);

    // Winner selection; with a single valid that one wins, on a tie the other-than-last wins.
    always_comb begin
        idx   = (valid == 2'b11) ? ~last_grant : ~valid[0];
        grant = 2'b00;
        if (en && (valid != 2'b00)) grant = idx ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/ieee754_op_arbiter.sv
// Shares one combinational FP unit between two requesters: accept, hold operands, capture, respond.
module ieee754_op_arbiter
    import ieee754_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [FP_WIDTH-1:0] req0_a,
    input  logic [FP_WIDTH-1:0] req0_b,
    input  logic [1:0]          req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [FP_WIDTH-1:0] req1_a,
    input  logic [FP_WIDTH-1:0] req1_b,
    input  logic [1:0]          req1_op,
    output logic [FP_WIDTH-1:0] fpu_a,
    output logic [FP_WIDTH-1:0] fpu_b,
    output logic [1:0]          fpu_op_sel,
    input  logic [FP_WIDTH-1:0] fpu_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [FP_WIDTH-1:0] rsp_result,
    output logic                rsp_id,
    output logic [1:0]          rsp_op,
    output logic                busy
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;
    logic             win;
    fp_req_t          sel;

    ieee754_rr_arbiter u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .en         (state == ST_IDLE),
        .grant      (grant),
        .idx        (win)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign busy       = (state != ST_IDLE);

    // Operand mux feeding the FP-unit registers at the accept edge.
    always_comb begin
        sel = win ? fp_req_t'{req1_a, req1_b, req1_op} : fp_req_t'{req0_a, req0_b, req0_op};
    end

    // Control FSM plus operand/response registers; fpu_* are only written on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            fpu_a      <= '0;
            fpu_b      <= '0;
            fpu_op_sel <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= 1'b0;
            rsp_op     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        fpu_a      <= sel.a;
                        fpu_b      <= sel.b;
                        fpu_op_sel <= sel.op;
                        rsp_id     <= win;
                        rsp_op     <= sel.op;
                        last_grant <= win;
                        cnt        <= CNT_LOAD;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cnt == '0) begin
                        rsp_result <= fpu_result;
                        rsp_valid  <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ieee754_op_arbiter.sv
// Directed self-checking bench for ieee754_op_arbiter with a table-driven FP unit stand-in.
module tb_ieee754_op_arbiter;
    import ieee754_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [31:0] fpu_a, fpu_b, fpu_result, rsp_result;
    logic [1:0]  fpu_op_sel, rsp_op;
    logic        rsp_valid, rsp_id, busy;
    logic        rsp_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] F4_75 = 32'h40980000, F2_125 = 32'h40080000;
    localparam logic [31:0] F9_5 = 32'h41180000, F3_75 = 32'h40700000;

    ieee754_op_arbiter #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op_sel(fpu_op_sel), .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_id(rsp_id), .rsp_op(rsp_op), .busy(busy)
    );

    always #5 clk = ~clk;

    // FP unit stand-in: hand-computed results for the operand sets used here, quiet NaN otherwise.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (a == F4_75 && b == F2_125 && op == OP_ADD) return 32'h40DC0000;
        if (a == F4_75 && b == F2_125 && op == OP_SUB) return 32'h40280000;
        if (a == F9_5  && b == F3_75  && op == OP_MUL) return 32'h420E8000;
        if (a == F9_5  && b == F3_75  && op == OP_ADD) return 32'h41540000;
        return 32'h7FC00000;
    endfunction

    assign fpu_result = fp_model(fpu_a, fpu_b, fpu_op_sel);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".fpu_a"}, fpu_a, 32'h0);
        chk({tag, ".fpu_b"}, fpu_b, 32'h0);
        chk({tag, ".fpu_op"}, {30'h0, fpu_op_sel}, 32'h0);
        chk({tag, ".rsp"}, {27'h0, rsp_valid, rsp_id, rsp_op, busy}, 32'h0);
        chk({tag, ".rsp_result"}, rsp_result, 32'h0);
        chk({tag, ".readies"}, {30'h0, req1_ready, req0_ready}, 32'h0);
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] res, input logic id, input logic [1:0] op);
        chk({tag, ".valid"}, {31'h0, rsp_valid}, 32'h1);
        chk({tag, ".result"}, rsp_result, res);
        chk({tag, ".id"}, {31'h0, rsp_id}, {31'h0, id});
        chk({tag, ".op"}, {30'h0, rsp_op}, {30'h0, op});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_acc;
        int n_acc;
        int stray;
        logic [31:0] held;

        // Asynchronous reset in the middle of a cycle.
        #3 rst_n = 1'b0;
        #1 chk_reset_state("reset");
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Single request on req0.
        req0_valid = 1'b1; req0_a = F4_75; req0_b = F2_125; req0_op = OP_ADD; rsp_ready = 1'b1;
        #1 chk("single.ready", {30'h0, req1_ready, req0_ready}, 32'h1);
        tick(); req0_valid = 1'b0;
        #1 chk("single.ready_after", {30'h0, req1_ready, req0_ready}, 32'h0);
        chk("single.busy", {31'h0, busy}, 32'h1);
        chk("single.fpu_a", fpu_a, F4_75);
        chk("single.fpu_b", fpu_b, F2_125);
        chk("single.valid_e0", {31'h0, rsp_valid}, 32'h0);
        tick(); chk("single.valid_e1", {31'h0, rsp_valid}, 32'h0);
        tick(); chk_rsp("single", 32'h40DC0000, 1'b0, OP_ADD);
        tick(); chk("single.hs", {30'h0, rsp_valid, busy}, 32'h0);
        chk("single.fpu_hold", fpu_a, F4_75);

        // Restore last_grant to its reset value so req0 takes the first tie.
        #3 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Tie: both requesters held.
        req0_valid = 1'b1; req0_a = F4_75; req0_b = F2_125; req0_op = OP_SUB;
        req1_valid = 1'b1; req1_a = F9_5;  req1_b = F3_75;  req1_op = OP_MUL;
        #1 chk("tie1.ready", {30'h0, req1_ready, req0_ready}, 32'h1);
        tick(); chk("tie1.issue_ready", {30'h0, req1_ready, req0_ready}, 32'h0);
        tick();
        tick(); chk_rsp("tie1", 32'h40280000, 1'b0, OP_SUB);
        tick(); #1 chk("tie2.ready", {30'h0, req1_ready, req0_ready}, 32'h2);
        tick(); chk("tie2.fpu_op", {30'h0, fpu_op_sel}, {30'h0, OP_MUL});
        tick();
        tick(); chk_rsp("tie2", 32'h420E8000, 1'b1, OP_MUL);
        tick(); #1 chk("tie3.ready", {30'h0, req1_ready, req0_ready}, 32'h1);

        // Backpressure on the repeated-tie operation.
        rsp_ready = 1'b0;
        tick(); tick(); tick();
        chk_rsp("bp", 32'h40280000, 1'b0, OP_SUB);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_rsp("bp.hold", 32'h40280000, 1'b0, OP_SUB);
            chk("bp.readies", {30'h0, req1_ready, req0_ready}, 32'h0);
            chk("bp.busy", {31'h0, busy}, 32'h1);
        end
        rsp_ready = 1'b1;
        tick(); chk("bp.hs", {30'h0, rsp_valid, busy}, 32'h0);
        #1 chk("bp.next_grant", {30'h0, req1_ready, req0_ready}, 32'h2);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1 chk("drop.readies", {30'h0, req1_ready, req0_ready}, 32'h0);
        tick(); chk("drop.busy", {31'h0, busy}, 32'h0);

        // Reset while an operation is in ISSUE.
        req0_valid = 1'b1; req0_a = F4_75; req0_b = F2_125; req0_op = OP_ADD;
        tick(); req0_valid = 1'b0;
        chk("rst_issue.busy", {31'h0, busy}, 32'h1);
        #3 rst_n = 1'b0;
        #1 chk_reset_state("rst_issue");
        @(negedge clk); rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid !== 1'b0) stray++;
        end
        chk("rst_issue.no_rsp", stray, 32'h0);
        req1_valid = 1'b1; req1_a = F9_5; req1_b = F3_75; req1_op = OP_ADD;
        #1 chk("lone1.ready", {30'h0, req1_ready, req0_ready}, 32'h2);
        tick(); req1_valid = 1'b0;
        tick();
        tick(); chk_rsp("lone1", 32'h41540000, 1'b1, OP_ADD);
        tick(); chk("lone1.hs", {30'h0, rsp_valid, busy}, 32'h0);

        // Throughput: req0 held continuously, consumer always ready.
        req0_valid = 1'b1; req0_a = F9_5; req0_b = F3_75; req0_op = OP_ADD;
        last_acc = -1; n_acc = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            #1;
            if (req0_ready) begin
                if (last_acc >= 0) chk("tput.interval", cyc - last_acc, 32'd4);
                last_acc = cyc;
                n_acc++;
            end
            if (rsp_valid) begin
                held = rsp_result;
                chk("tput.result", held, 32'h41540000);
            end
            tick();
        end
        chk("tput.accepts", n_acc, 32'd4);
        req0_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
